bus_activity_monitor: RTL

BUS_ACTIVITY_MONITOR -- requirements
Module: bus_activity_monitor

---
 rtl/bus_activity_monitor_pkg.sv | 26 ++
 rtl/bus_activity_monitor_counter.sv | 27 ++
 rtl/bus_activity_monitor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_activity_monitor_pkg.sv
// Shared types and constants for the bus activity monitor.
//   state_t      : FSM state encoding (IDLE, ACTIVE, ABORT)
//   ERR_*        : bit positions inside errorFlags
//   PROF_EVT_*   : event indices on the profiling counter that the monitor feeds
package bus_activity_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_t;

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_BUS     = 0;
  localparam int unsigned ERR_OVERRUN = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  localparam int unsigned BEAT_W  = 9;
  localparam int unsigned BURST_W = 8;
  localparam int unsigned TMO_W   = 10;

  // Profiling counter event inputs; busIdle drives the bus-idle event.
  localparam int unsigned PROF_EVT_BUS_IDLE = 0;
  localparam int unsigned PROF_EVT_NUM      = 4;

endpackage

// File: rtl/bus_activity_monitor_counter.sv
// Generic synchronous counter.
//   clock, reset : clock, asynchronous active-high reset
//   clr          : synchronous clear to zero (wins over en)
//   en           : count one step in direction UP
//   count        : current value
module bus_activity_monitor_counter #(
  parameter int unsigned WIDTH = 10,
  parameter bit          UP    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= UP ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_activity_monitor.sv
// Bus activity monitor: tracks one open bus transaction at a time, counts
// data beats, flags bus errors, beat overruns and watchdog timeouts.
//   clock, reset          : clock, asynchronous active-high reset
//   beginTransactionIn    : start strobe (samples readNotWriteIn, burstSizeIn)
//   endTransactionIn      : end strobe
//   dataValidIn           : one data beat this cycle
//   busErrorIn            : bus error strobe
//   clearError            : clears sticky errorFlags
//   busIdle               : no transaction open
//   readActive/writeActive: open transaction direction
//   beatCount             : beats in current/last transaction
//   transactionDone       : one-cycle pulse on normal completion
//   errorFlags            : sticky {timeout, overrun, bus error}
module bus_activity_monitor
  import bus_activity_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                beginTransactionIn,
  input  logic                endTransactionIn,
  input  logic                dataValidIn,
  input  logic                busErrorIn,
  input  logic                readNotWriteIn,
  input  logic [BURST_W-1:0]  burstSizeIn,
  input  logic                clearError,
  output logic                busIdle,
  output logic                readActive,
  output logic                writeActive,
  output logic [BEAT_W-1:0]   beatCount,
  output logic                transactionDone,
  output logic [ERR_W-1:0]    errorFlags
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  state_t               r_state;
  logic                 r_rnw;
  logic [BURST_W-1:0]   r_burst;

  state_t               w_state_nxt;
  logic                 w_rnw_nxt;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic                 w_done_nxt;
  logic [ERR_W-1:0]     w_set;
  logic [ERR_W-1:0]     w_flags_nxt;
  logic [BEAT_W-1:0]    w_beat_inc;
  logic [BEAT_W:0]      w_beat_limit;
  logic                 w_overrun;
  logic [TMO_W-1:0]     w_tmo_count;
  logic                 w_tmo_last;
  logic                 w_active;

  assign w_active = (r_state == ACTIVE);

  // Watchdog: counts ACTIVE cycles, held at zero everywhere else.
  bus_activity_monitor_counter #(
    .WIDTH (TMO_W),
    .UP    (1'b1)
  ) u_tmo_counter (
    .clock (clock),
    .reset (reset),
    .clr   (!w_active),
    .en    (w_active),
    .count (w_tmo_count)
  );

  // Count value TIMEOUT-1 marks the last allowed ACTIVE cycle.
  assign w_tmo_last = (w_tmo_count == TMO_W'(TIMEOUT - 1));

  assign w_beat_inc   = (beatCount == BEAT_MAX) ? beatCount : beatCount + BEAT_W'(1);
  assign w_beat_limit = (BEAT_W + 1)'(r_burst) + (BEAT_W + 1)'(1);
  assign w_overrun    = ({1'b0, w_beat_inc} > w_beat_limit);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_rnw_nxt   = r_rnw;
    w_burst_nxt = r_burst;
    w_beat_nxt  = beatCount;
    w_done_nxt  = 1'b0;
    w_set       = '0;

    case (r_state)
      IDLE: begin
        if (beginTransactionIn) begin
          if (endTransactionIn) begin
            // Zero-beat transaction: completes without leaving IDLE.
            w_done_nxt = 1'b1;
            w_beat_nxt = dataValidIn ? BEAT_W'(1) : '0;
          end else begin
            w_state_nxt = ACTIVE;
            w_rnw_nxt   = readNotWriteIn;
            w_burst_nxt = burstSizeIn;
            w_beat_nxt  = '0;
          end
        end
      end
      ACTIVE: begin
        if (dataValidIn) begin
          w_beat_nxt = w_beat_inc;
          if (w_overrun) begin
            w_set[ERR_OVERRUN] = 1'b1;
          end
        end
        // Bus error beats a same-cycle end; a normal end beats the watchdog.
        if (busErrorIn) begin
          w_state_nxt    = ABORT;
          w_set[ERR_BUS] = 1'b1;
        end else if (endTransactionIn) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_tmo_last) begin
          w_state_nxt        = ABORT;
          w_set[ERR_TIMEOUT] = 1'b1;
        end
      end
      ABORT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A flag-setting event wins over a simultaneous clear.
    w_flags_nxt = (clearError ? '0 : errorFlags) | w_set;
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rnw           <= 1'b0;
      r_burst         <= '0;
      busIdle         <= 1'b1;
      readActive      <= 1'b0;
      writeActive     <= 1'b0;
      beatCount       <= '0;
      transactionDone <= 1'b0;
      errorFlags      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_rnw           <= w_rnw_nxt;
      r_burst         <= w_burst_nxt;
      busIdle         <= (w_state_nxt == IDLE);
      readActive      <= (w_state_nxt == ACTIVE) && w_rnw_nxt;
      writeActive     <= (w_state_nxt == ACTIVE) && !w_rnw_nxt;
      beatCount       <= w_beat_nxt;
      transactionDone <= w_done_nxt;
      errorFlags      <= w_flags_nxt;
    end
  end

endmodule
